// File: rtl/imem_pkg.sv
// Shared types and width helpers for the instruction-memory response block.
package imem_pkg;

    localparam int DEF_WORD_SIZE   = 4;
    localparam int DEF_DEPTH_WORDS = 1024;
    localparam int DEF_WORD_BITS   = DEF_WORD_SIZE * 8;

    // Byte-offset bits inside a word; zero for single-byte words.
    function automatic int off_w(input int word_size);
        return (word_size > 1) ? $clog2(word_size) : 0;
    endfunction

    function automatic int idx_w(input int depth_words);
        return (depth_words > 1) ? $clog2(depth_words) : 1;
    endfunction

    typedef struct packed {
        logic                     valid;
        logic                     error;
        logic [DEF_WORD_BITS-1:0] data;
    } imem_rsp_t;

endpackage

// File: rtl/imem_resp_pipe.sv
// Fixed-latency response delay line; a synchronous flush drops everything in flight.
module imem_resp_pipe
    import imem_pkg::*;
#(
    parameter int  LATENCY = 2,
    parameter type rsp_t   = imem_rsp_t
) (
    input  logic clk,
    input  logic reset,
    input  rsp_t rsp_in,
    output rsp_t rsp_out
);

    rsp_t stage_q [LATENCY];
    rsp_t stage_d [LATENCY];

    always_comb begin
        stage_d[0] = rsp_in;
        for (int i = 1; i < LATENCY; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Data is flushed as well so the outputs read as zero right after reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LATENCY; i++) begin
            stage_q[i] <= reset ? '0 : stage_d[i];
        end
    end

    assign rsp_out = stage_q[LATENCY-1];

endmodule

// File: rtl/imem_resp.sv
// Word-addressed instruction memory with a byte-lane load port and fixed-latency
// read responses that flag misaligned or out-of-range requests.
module imem_resp
    import imem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int WORD_SIZE   = DEF_WORD_SIZE,
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int LATENCY     = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    read_request,
    input  logic [ADDR_WIDTH-1:0]   read_addr,
    output logic                    mem_read_data_ready,
    output logic [WORD_SIZE*8-1:0]  mem_read_data,
    output logic                    mem_read_error,
    input  logic                    write_enable,
    input  logic [ADDR_WIDTH-1:0]   write_addr,
    input  logic [WORD_SIZE*8-1:0]  write_data,
    input  logic [WORD_SIZE-1:0]    write_byte_en,
    output logic [31:0]             req_count,
    output logic [15:0]             err_count
);

    localparam int          OFF_W      = off_w(WORD_SIZE);
    localparam int          IDX_W      = idx_w(DEPTH_WORDS);
    localparam int          WORD_BITS  = WORD_SIZE * 8;
    localparam logic [63:0] SPAN_BYTES = 64'(DEPTH_WORDS) * 64'(WORD_SIZE);

    typedef struct packed {
        logic                 valid;
        logic                 error;
        logic [WORD_BITS-1:0] data;
    } rsp_t;

    function automatic logic misaligned(input logic [ADDR_WIDTH-1:0] a);
        return (a & ADDR_WIDTH'(WORD_SIZE - 1)) != '0;
    endfunction

    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
        return 64'(a) >= SPAN_BYTES;
    endfunction

    logic [WORD_BITS-1:0] mem_q [DEPTH_WORDS];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             rd_err;
    logic             wr_drop;
    logic             accept;
    logic             do_write;
    rsp_t             rsp_in;
    rsp_t             rsp_out;
    logic [31:0]      req_count_d, req_count_q;
    logic [15:0]      err_count_d, err_count_q;

    always_comb begin
        rd_idx   = read_addr[OFF_W +: IDX_W];
        wr_idx   = write_addr[OFF_W +: IDX_W];
        rd_err   = misaligned(read_addr) | out_of_range(read_addr);
        wr_drop  = out_of_range(write_addr);
        accept   = read_request & ~reset;
        do_write = write_enable & ~reset & ~wr_drop;

        // Array is sampled in the acceptance cycle, before any same-cycle write lands.
        rsp_in       = '0;
        rsp_in.valid = accept;
        rsp_in.error = accept & rd_err;
        if (accept && !rd_err) begin
            rsp_in.data = mem_q[rd_idx];
        end

        req_count_d = req_count_q + 32'(accept);
        err_count_d = err_count_q;
        if (accept && rd_err && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    // Storage carries no reset so contents survive it.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < WORD_SIZE; b++) begin
                if (write_byte_en[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= write_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_count_q <= '0;
            err_count_q <= '0;
        end else begin
            req_count_q <= req_count_d;
            err_count_q <= err_count_d;
        end
    end

    imem_resp_pipe #(
        .LATENCY (LATENCY),
        .rsp_t   (rsp_t)
    ) u_pipe (
        .clk     (clk),
        .reset   (reset),
        .rsp_in  (rsp_in),
        .rsp_out (rsp_out)
    );

    assign mem_read_data_ready = rsp_out.valid;
    assign mem_read_error      = rsp_out.error;
    assign mem_read_data       = rsp_out.data;
    assign req_count           = req_count_q;
    assign err_count           = err_count_q;

endmodule

// File: tb/tb_imem_resp.sv
// Scoreboard bench for imem_resp: expected responses are queued at drive time
// and matched, with their arrival cycle, when the DUT reports them.
module tb_imem_resp;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        read_request;
    logic [31:0] read_addr;
    logic        mem_read_data_ready;
    logic [31:0] mem_read_data;
    logic        mem_read_error;
    logic        write_enable;
    logic [31:0] write_addr;
    logic [31:0] write_data;
    logic [3:0]  write_byte_en;
    logic [31:0] req_count;
    logic [15:0] err_count;

    always #5 clk = ~clk;

    imem_resp #(
        .ADDR_WIDTH  (32),
        .WORD_SIZE   (4),
        .DEPTH_WORDS (1024),
        .LATENCY     (LAT)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .read_request        (read_request),
        .read_addr           (read_addr),
        .mem_read_data_ready (mem_read_data_ready),
        .mem_read_data       (mem_read_data),
        .mem_read_error      (mem_read_error),
        .write_enable        (write_enable),
        .write_addr          (write_addr),
        .write_data          (write_data),
        .write_byte_en       (write_byte_en),
        .req_count           (req_count),
        .err_count           (err_count)
    );

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_mem [1024];
    logic [31:0] m_req;
    logic [15:0] m_err;
    int          cyc    = 0;
    int          n_cmp  = 0;
    int          n_bad  = 0;
    bit          mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive(input logic rd, input logic [31:0] ra, input logic we,
                         input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] be);
        exp_t e;
        @(negedge clk);
        read_request  = rd;
        read_addr     = ra;
        write_enable  = we;
        write_addr    = wa;
        write_data    = wd;
        write_byte_en = be;
        if (!reset && rd) begin
            e.cyc  = cyc + LAT;
            e.err  = (ra[1:0] != 2'b00) || (ra >= 32'h1000);
            e.data = e.err ? 32'h0 : model_mem[ra[11:2]];
            sb.push_back(e);
            m_req = m_req + 32'd1;
            if (e.err && m_err != 16'hFFFF) m_err = m_err + 16'd1;
        end
        if (!reset && we && wa < 32'h1000) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) model_mem[wa[11:2]][8*b +: 8] = wd[8*b +: 8];
            end
        end
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic rd(input logic [31:0] a);
        drive(1'b1, a, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        drive(1'b0, 32'h0, 1'b1, a, d, be);
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_req_count"}, 64'(req_count), 64'(m_req));
        chk({tag, "_err_count"}, 64'(err_count), 64'(m_err));
    endtask

    // Reset with a read and a full-word write held high, both of which must be ignored.
    task automatic do_reset(input int n);
        @(negedge clk);
        reset         = 1'b1;
        read_request  = 1'b1;
        read_addr     = 32'h0;
        write_enable  = 1'b1;
        write_addr    = 32'h0;
        write_data    = 32'hDEAD_BEEF;
        write_byte_en = 4'hF;
        while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
        m_req = '0;
        m_err = '0;
        repeat (n) @(negedge clk);
        reset        = 1'b0;
        read_request = 1'b0;
        write_enable = 1'b0;
        check_counts("post_reset");
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (mem_read_data_ready === 1'b1) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_ready", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
                        chk("rsp_error", 64'(mem_read_error), 64'(e.err));
                        chk("rsp_data", 64'(mem_read_data), 64'(e.data));
                    end
                end else begin
                    chk("idle_outputs", 64'({mem_read_data_ready, mem_read_error, mem_read_data}), 64'd0);
                    if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                        chk("rsp_missing", 64'(cyc), 64'(sb[0].cyc + 1000));
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        reset         = 1'b1;
        read_request  = 1'b0;
        read_addr     = '0;
        write_enable  = 1'b0;
        write_addr    = '0;
        write_data    = '0;
        write_byte_en = '0;
        m_req         = '0;
        m_err         = '0;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        do_reset(2);

        // Preload
        wr(32'h0,   32'h1111_1111, 4'hF);
        wr(32'h4,   32'h2222_2222, 4'hF);
        wr(32'h8,   32'h3333_3333, 4'hF);
        wr(32'hC,   32'h4444_4444, 4'hF);
        wr(32'h14,  32'hAABB_CCDD, 4'hF);
        wr(32'h18,  32'h6666_6666, 4'hF);
        wr(32'hFFC, 32'hCAFE_F00D, 4'hF);
        idle();

        // Back-to-back reads
        rd(32'h0); rd(32'h4); rd(32'h8); rd(32'hC);
        repeat (3) idle();
        check_counts("burst");

        // Error requests and the top-of-range boundary
        rd(32'h2);
        idle();
        chk("err_after_misaligned", 64'(err_count), 64'd1);
        rd(32'h1000);
        rd(32'hFFC);
        rd(32'h3);
        repeat (3) idle();
        check_counts("errors");

        // Same-cycle write and read to one word
        drive(1'b1, 32'h14, 1'b1, 32'h14, 32'h0000_0012, 4'b0001);
        rd(32'h14);

        // Dropped out-of-range write, misaligned write lands in its word
        wr(32'h1000, 32'hFFFF_FFFF, 4'hF);
        wr(32'h1B,   32'h7700_0000, 4'b1000);
        rd(32'h0);
        rd(32'h18);
        repeat (3) idle();

        // Reset with responses in flight
        rd(32'h4); rd(32'h8); rd(32'hC);
        do_reset(2);
        repeat (4) idle();
        rd(32'h0); rd(32'h4); rd(32'h14);
        repeat (3) idle();
        check_counts("after_reset_reads");

        // Counter wrap and saturation from preloaded state
        idle();
        dut.req_count_q = 32'hFFFF_FFFE;
        dut.err_count_q = 16'hFFFE;
        m_req = 32'hFFFF_FFFE;
        m_err = 16'hFFFE;
        rd(32'h2); rd(32'h1000); rd(32'h6);
        idle();
        check_counts("wrap");
        chk("req_wrapped_to_1", 64'(req_count), 64'd1);
        rd(32'h1);
        idle();
        check_counts("saturate");

        repeat (LAT + 3) idle();
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_resp.md
IMEM_RESP -- requirements
Module: imem_resp

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte address width of the read/write ports.
REQ-002 Parameter WORD_SIZE, default 4, bytes per word; SHALL be a power of two.
REQ-003 Parameter DEPTH_WORDS, default 1024, storage words; SHALL be a power of two.
REQ-004 Parameter LATENCY, default 2, request-to-response cycles; SHALL be >= 1.
REQ-005 clk  input  1  clock; all state updates on posedge clk.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 read_request  input  1  read request, one per cycle when high.
REQ-008 read_addr  input  ADDR_WIDTH  byte address of the requested word.
REQ-009 mem_read_data_ready  output  1  response valid, one-cycle pulse per request.
REQ-010 mem_read_data  output  WORD_SIZE*8  response word, little-endian byte lanes.
REQ-011 mem_read_error  output  1  response is an error (misaligned or out of range); qualified by mem_read_data_ready.
REQ-012 write_enable  input  1  load-port write strobe.
REQ-013 write_addr  input  ADDR_WIDTH  byte address of the written word.
REQ-014 write_data  input  WORD_SIZE*8  write word.
REQ-015 write_byte_en  input  WORD_SIZE  per-byte write enable; bit i covers data bits [8i+7:8i].
REQ-016 req_count  output  32  accepted read requests since reset.
REQ-017 err_count  output  16  error responses since reset.

Function
REQ-018 Word index SHALL be read_addr[log2(WORD_SIZE) +: log2(DEPTH_WORDS)].
REQ-019 Request SHALL be misaligned when read_addr[log2(WORD_SIZE)-1:0] != 0.
REQ-020 Request SHALL be out of range when read_addr >= DEPTH_WORDS*WORD_SIZE.
REQ-021 Every cycle with read_request=1 SHALL be accepted; no backpressure exists.
REQ-022 Accepted request in cycle N SHALL produce mem_read_data_ready=1 in exactly cycle N+LATENCY.
REQ-023 Back-to-back requests SHALL yield back-to-back responses, in request order, no bubbles.
REQ-024 Read data SHALL be the array content at acceptance cycle N; same-cycle write to same word returns old data.
REQ-025 Error response: mem_read_data_ready=1, mem_read_error=1, mem_read_data=0.
REQ-026 When mem_read_data_ready=0, mem_read_data and mem_read_error SHALL be 0.
REQ-027 Write with write_enable=1 SHALL update only enabled byte lanes at the word indexed per REQ-018 from write_addr.
REQ-028 Write address low bits below WORD_SIZE SHALL be ignored; out-of-range writes SHALL be dropped silently.
REQ-029 req_count SHALL increment per accepted request and wrap from 2^32-1 to 0.
REQ-030 err_count SHALL increment per error request at acceptance and saturate at 16'hFFFF.
REQ-031 Storage array contents SHALL NOT be reset and SHALL survive reset.

Reset
REQ-032 During reset all pipeline stages SHALL be cleared; in-flight responses SHALL be discarded.
REQ-033 During and in the cycle after reset: mem_read_data_ready=0, mem_read_error=0, mem_read_data=0, req_count=0, err_count=0.
REQ-034 read_request and write_enable asserted while reset=1 SHALL be ignored.
REQ-035 First request after reset deasserts SHALL respond exactly LATENCY cycles later.

Structure
REQ-036 Package imem_pkg SHALL hold the response struct (valid, error, data) and width helper constants derived from WORD_SIZE and DEPTH_WORDS.
REQ-037 Sub-module imem_resp_pipe SHALL implement the LATENCY-deep response shift register with synchronous flush on reset.
REQ-038 The storage array and the counters SHALL live in imem_resp.

Verification
REQ-039 Load words 0..3 = 0x11111111..0x44444444, request 0x0,0x4,0x8,0xC back-to-back -> ready high 4 consecutive cycles starting LATENCY after the first request, data in order.
REQ-040 Request 0x2 -> ready=1, error=1, data=0, err_count=1; request 0x1000 (DEPTH_WORDS=1024) -> same error response, err_count=2.
REQ-041 Word 5 = 0xAABBCCDD, write 0x00000012 to 0x14 with byte_en=4'b0001 in the same cycle as read of 0x14 -> response 0xAABBCCDD; next read -> 0xAABBCC12.
REQ-042 Issue 3 requests, assert reset one cycle after the last -> no ready pulses after reset; req_count=0; memory contents unchanged on re-read.
REQ-043 Preload req_count near wrap via 2^32-2 forced-state or long run, plus 3 requests -> req_count wraps to 1; err_count held at 0xFFFF under further errors.
